// File: rtl/alu_issue_pkg.sv
// ALUfn codes, MIPS opcode/funct values and the decoded issue record shared by
// the decoder and the issue pipeline.
package alu_issue_pkg;

  localparam int DW = 32;

  // ALUfn = {subtract, bool1, bool0, shft, math}
  localparam logic [4:0] FN_ADD  = 5'b00001;
  localparam logic [4:0] FN_SUB  = 5'b10001;
  localparam logic [4:0] FN_SLL  = 5'b00010;
  localparam logic [4:0] FN_SRL  = 5'b01010;
  localparam logic [4:0] FN_SRA  = 5'b01110;
  localparam logic [4:0] FN_AND  = 5'b00000;
  localparam logic [4:0] FN_OR   = 5'b00100;
  localparam logic [4:0] FN_XOR  = 5'b01000;
  localparam logic [4:0] FN_NOR  = 5'b01100;
  localparam logic [4:0] FN_SLT  = 5'b10011;
  localparam logic [4:0] FN_SLTU = 5'b10111;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] F_SLL  = 6'h00;
  localparam logic [5:0] F_SRL  = 6'h02;
  localparam logic [5:0] F_SRA  = 6'h03;
  localparam logic [5:0] F_SLLV = 6'h04;
  localparam logic [5:0] F_SRLV = 6'h06;
  localparam logic [5:0] F_SRAV = 6'h07;
  localparam logic [5:0] F_ADD  = 6'h20;
  localparam logic [5:0] F_ADDU = 6'h21;
  localparam logic [5:0] F_SUB  = 6'h22;
  localparam logic [5:0] F_SUBU = 6'h23;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_XOR  = 6'h26;
  localparam logic [5:0] F_NOR  = 6'h27;
  localparam logic [5:0] F_SLT  = 6'h2A;
  localparam logic [5:0] F_SLTU = 6'h2B;

  typedef struct packed {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [4:0]    fn;
    logic          illegal;
  } issue_t;

  // Reset value of the D stage; also what an unsupported instruction issues.
  localparam issue_t ISSUE_IDLE    = '{a: '0, b: '0, fn: FN_ADD, illegal: 1'b0};
  localparam issue_t ISSUE_ILLEGAL = '{a: '0, b: '0, fn: FN_ADD, illegal: 1'b1};

  function automatic logic [DW-1:0] sext16(input logic [15:0] imm);
    return {{(DW-16){imm[15]}}, imm};
  endfunction

  function automatic logic [DW-1:0] zext16(input logic [15:0] imm);
    return {{(DW-16){1'b0}}, imm};
  endfunction

endpackage

// File: rtl/alu_issue_if.sv
// Request, ALU-drive and response signals of the ALU issue unit.
// slave: the issue unit's view; master: the register-read / ALU / writeback side.
interface alu_issue_if #(
  parameter int N = 32
);

  logic          req_valid;
  logic          req_ready;
  logic [5:0]    req_op;
  logic [5:0]    req_funct;
  logic [4:0]    req_shamt;
  logic [15:0]   req_imm;
  logic [N-1:0]  req_rs;
  logic [N-1:0]  req_rt;

  logic [N-1:0]  alu_A;
  logic [N-1:0]  alu_B;
  logic [4:0]    alu_fn;
  logic [N-1:0]  alu_R;
  logic [3:0]    alu_flags;

  logic          rsp_valid;
  logic          rsp_ready;
  logic [N-1:0]  rsp_result;
  logic [3:0]    rsp_flags;
  logic          rsp_illegal;

  modport slave (
    input  req_valid, req_op, req_funct, req_shamt, req_imm, req_rs, req_rt,
    output req_ready,
    output alu_A, alu_B, alu_fn,
    input  alu_R, alu_flags,
    output rsp_valid, rsp_result, rsp_flags, rsp_illegal,
    input  rsp_ready
  );

  modport master (
    output req_valid, req_op, req_funct, req_shamt, req_imm, req_rs, req_rt,
    input  req_ready,
    input  alu_A, alu_B, alu_fn,
    output alu_R, alu_flags,
    input  rsp_valid, rsp_result, rsp_flags, rsp_illegal,
    output rsp_ready
  );

endinterface

// File: rtl/alu_issue_decode.sv
// Combinational MIPS opcode/funct decoder: forms ALU operands A/B and ALUfn,
// and flags unsupported instructions as illegal (issued as 0+0).
module alu_issue_decode
  import alu_issue_pkg::*;
(
  input  logic [5:0]    op_i,
  input  logic [5:0]    funct_i,
  input  logic [4:0]    shamt_i,
  input  logic [15:0]   imm_i,
  input  logic [DW-1:0] rs_i,
  input  logic [DW-1:0] rt_i,
  output issue_t        issue_o
);

  logic [DW-1:0] imm_sext;
  logic [DW-1:0] imm_zext;
  logic [DW-1:0] shamt_zext;

  assign imm_sext   = sext16(imm_i);
  assign imm_zext   = zext16(imm_i);
  assign shamt_zext = {{(DW-5){1'b0}}, shamt_i};

  always_comb begin
    issue_o = '{a: rs_i, b: rt_i, fn: FN_ADD, illegal: 1'b0};
    case (op_i)
      OP_RTYPE: begin
        case (funct_i)
          F_ADD, F_ADDU: issue_o.fn = FN_ADD;
          F_SUB, F_SUBU: issue_o.fn = FN_SUB;
          F_AND:         issue_o.fn = FN_AND;
          F_OR:          issue_o.fn = FN_OR;
          F_XOR:         issue_o.fn = FN_XOR;
          F_NOR:         issue_o.fn = FN_NOR;
          F_SLT:         issue_o.fn = FN_SLT;
          F_SLTU:        issue_o.fn = FN_SLTU;
          // Constant shifts carry the amount in A; the ALU shifts B.
          F_SLL: begin
            issue_o.fn = FN_SLL;
            issue_o.a  = shamt_zext;
          end
          F_SRL: begin
            issue_o.fn = FN_SRL;
            issue_o.a  = shamt_zext;
          end
          F_SRA: begin
            issue_o.fn = FN_SRA;
            issue_o.a  = shamt_zext;
          end
          F_SLLV:        issue_o.fn = FN_SLL;
          F_SRLV:        issue_o.fn = FN_SRL;
          F_SRAV:        issue_o.fn = FN_SRA;
          default:       issue_o = ISSUE_ILLEGAL;
        endcase
      end
      OP_ADDI, OP_ADDIU, OP_LW, OP_SW: begin
        issue_o.fn = FN_ADD;
        issue_o.b  = imm_sext;
      end
      OP_SLTI: begin
        issue_o.fn = FN_SLT;
        issue_o.b  = imm_sext;
      end
      OP_SLTIU: begin
        issue_o.fn = FN_SLTU;
        issue_o.b  = imm_sext;
      end
      OP_ANDI: begin
        issue_o.fn = FN_AND;
        issue_o.b  = imm_zext;
      end
      OP_ORI: begin
        issue_o.fn = FN_OR;
        issue_o.b  = imm_zext;
      end
      OP_XORI: begin
        issue_o.fn = FN_XOR;
        issue_o.b  = imm_zext;
      end
      OP_LUI: begin
        issue_o.fn = FN_SLL;
        issue_o.a  = DW'(16);
        issue_o.b  = imm_zext;
      end
      OP_BEQ, OP_BNE: issue_o.fn = FN_SUB;
      default:        issue_o = ISSUE_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/alu_issue_unit.sv
// Two-stage ALU issue pipeline: D drives the ALU, W holds R/flags until accepted.
// Statistics counters stat_issued/stat_illegal exist only with ALU_ISSUE_STATS_EN.
module alu_issue_unit
  import alu_issue_pkg::*;
#(
  parameter int N       = 32,
  parameter int STATS_W = 16
) (
  input  logic       clock,
  input  logic       reset_n,
  alu_issue_if.slave bus
`ifdef ALU_ISSUE_STATS_EN
  ,
  output logic [STATS_W-1:0] stat_issued,
  output logic [STATS_W-1:0] stat_illegal
`endif
);

  if (N != DW || STATS_W < 1) begin : g_bad_cfg
    $error("alu_issue_unit: N must be 32 and STATS_W positive");
  end

  issue_t       dec;
  issue_t       d_q, d_d;
  logic         d_valid_q, d_valid_d;
  logic         w_valid_q, w_valid_d;
  logic [N-1:0] w_result_q, w_result_d;
  logic [3:0]   w_flags_q, w_flags_d;
  logic         w_illegal_q, w_illegal_d;
  logic         w_adv;
  logic         req_ready;
  logic         accept;

  alu_issue_decode u_decode (
    .op_i    (bus.req_op),
    .funct_i (bus.req_funct),
    .shamt_i (bus.req_shamt),
    .imm_i   (bus.req_imm),
    .rs_i    (bus.req_rs),
    .rt_i    (bus.req_rt),
    .issue_o (dec)
  );

  // W takes the D instruction whenever it is empty or being drained this cycle.
  assign w_adv     = d_valid_q & (~w_valid_q | bus.rsp_ready);
  assign req_ready = ~d_valid_q | w_adv;
  assign accept    = bus.req_valid & req_ready;

  always_comb begin
    d_d       = d_q;
    d_valid_d = d_valid_q;
    if (accept) begin
      d_d       = dec;
      d_valid_d = 1'b1;
    end else if (w_adv) begin
      d_valid_d = 1'b0;
    end
  end

  always_comb begin
    w_valid_d   = w_valid_q;
    w_result_d  = w_result_q;
    w_flags_d   = w_flags_q;
    w_illegal_d = w_illegal_q;
    if (w_adv) begin
      w_valid_d   = 1'b1;
      w_result_d  = bus.alu_R;
      w_flags_d   = bus.alu_flags;
      w_illegal_d = d_q.illegal;
    end else if (bus.rsp_ready) begin
      w_valid_d   = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      d_q         <= ISSUE_IDLE;
      d_valid_q   <= 1'b0;
      w_valid_q   <= 1'b0;
      w_result_q  <= '0;
      w_flags_q   <= '0;
      w_illegal_q <= 1'b0;
    end else begin
      d_q         <= d_d;
      d_valid_q   <= d_valid_d;
      w_valid_q   <= w_valid_d;
      w_result_q  <= w_result_d;
      w_flags_q   <= w_flags_d;
      w_illegal_q <= w_illegal_d;
    end
  end

  assign bus.req_ready   = req_ready;
  assign bus.alu_A       = d_q.a;
  assign bus.alu_B       = d_q.b;
  assign bus.alu_fn      = d_q.fn;
  assign bus.rsp_valid   = w_valid_q;
  assign bus.rsp_result  = w_result_q;
  assign bus.rsp_flags   = w_flags_q;
  assign bus.rsp_illegal = w_illegal_q;

`ifdef ALU_ISSUE_STATS_EN
  logic [STATS_W-1:0] stat_issued_q, stat_issued_d;
  logic [STATS_W-1:0] stat_illegal_q, stat_illegal_d;
  logic               rsp_fire;

  assign rsp_fire = w_valid_q & bus.rsp_ready;

  always_comb begin
    stat_issued_d  = stat_issued_q;
    stat_illegal_d = stat_illegal_q;
    if (rsp_fire) begin
      stat_issued_d = stat_issued_q + STATS_W'(1);
      if (w_illegal_q) begin
        stat_illegal_d = stat_illegal_q + STATS_W'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stat_issued_q  <= '0;
      stat_illegal_q <= '0;
    end else begin
      stat_issued_q  <= stat_issued_d;
      stat_illegal_q <= stat_illegal_d;
    end
  end

  assign stat_issued  = stat_issued_q;
  assign stat_illegal = stat_illegal_q;
`endif

endmodule

// File: tb/tb_alu_issue_unit.sv
// Directed bench for alu_issue_unit: instruction-level model plus ALU stand-in,
// checked every cycle, with literal expectations pinning key cases.
module tb_alu_issue_unit;

  localparam int N       = 32;
  localparam int STATS_W = 16;

  localparam logic [4:0] C_ADD = 5'b00001, C_SUB = 5'b10001, C_SLL = 5'b00010,
                         C_SRL = 5'b01010, C_SRA = 5'b01110, C_AND = 5'b00000,
                         C_OR  = 5'b00100, C_XOR = 5'b01000, C_NOR = 5'b01100,
                         C_SLT = 5'b10011, C_SLTU = 5'b10111;

  typedef struct {
    logic [5:0]  op;
    logic [5:0]  funct;
    logic [4:0]  sh;
    logic [15:0] imm;
    logic [31:0] rs;
    logic [31:0] rt;
  } vec_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  fn;
    logic        ill;
    logic [31:0] res;
    logic [3:0]  flg;
  } exp_t;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  alu_issue_if #(.N(N)) bus ();

`ifdef ALU_ISSUE_STATS_EN
  logic [STATS_W-1:0] stat_issued;
  logic [STATS_W-1:0] stat_illegal;
`endif

  alu_issue_unit #(.N(N), .STATS_W(STATS_W)) u_dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
`ifdef ALU_ISSUE_STATS_EN
    ,
    .stat_issued  (stat_issued),
    .stat_illegal (stat_illegal)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  // kind: 0 none, 1 add (x+y), 2 subtract (x-y)
  function automatic logic [3:0] flags_of(input logic [31:0] r, input int kind,
                                          input logic [31:0] x, input logic [31:0] y);
    logic [32:0] w;
    logic c, v;
    c = 1'b0;
    v = 1'b0;
    if (kind == 1) begin
      w = {1'b0, x} + {1'b0, y};
      c = w[32];
      v = (x[31] == y[31]) && (r[31] != x[31]);
    end else if (kind == 2) begin
      w = {1'b0, x} + {1'b0, ~y} + 33'd1;
      c = w[32];
      v = (x[31] != y[31]) && (r[31] != x[31]);
    end
    return {r[31], v, c, (r == 32'd0)};
  endfunction

  // Stand-in for the external ALU: {flags, R} from A, B, ALUfn.
  function automatic logic [35:0] alu_eval(input logic [31:0] a, input logic [31:0] b,
                                           input logic [4:0] fn);
    logic [31:0] r;
    int kind;
    kind = 0;
    case (fn)
      C_ADD:   begin r = a + b; kind = 1; end
      C_SUB:   begin r = a - b; kind = 2; end
      C_SLL:   r = b << a[4:0];
      C_SRL:   r = b >> a[4:0];
      C_SRA:   r = $signed(b) >>> a[4:0];
      C_AND:   r = a & b;
      C_OR:    r = a | b;
      C_XOR:   r = a ^ b;
      C_NOR:   r = ~(a | b);
      C_SLT:   r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      C_SLTU:  r = (a < b) ? 32'd1 : 32'd0;
      default: r = 32'hDEAD_0000;
    endcase
    return {flags_of(r, kind, a, b), r};
  endfunction

  assign {bus.alu_flags, bus.alu_R} = alu_eval(bus.alu_A, bus.alu_B, bus.alu_fn);

  // Instruction-level expectation: what the MIPS instruction computes.
  function automatic exp_t exp_of(input vec_t v);
    exp_t e;
    logic [31:0] se, ze, y;
    int kind;
    se = {{16{v.imm[15]}}, v.imm};
    ze = {16'h0, v.imm};
    e.a = v.rs; e.b = v.rt; e.fn = C_ADD; e.ill = 1'b0; e.res = 32'd0;
    kind = 0; y = v.rt;
    if (v.op == 6'h00) begin
      case (v.funct)
        6'h20, 6'h21: begin e.fn = C_ADD; e.res = v.rs + v.rt; kind = 1; end
        6'h22, 6'h23: begin e.fn = C_SUB; e.res = v.rs - v.rt; kind = 2; end
        6'h24: begin e.fn = C_AND; e.res = v.rs & v.rt; end
        6'h25: begin e.fn = C_OR;  e.res = v.rs | v.rt; end
        6'h26: begin e.fn = C_XOR; e.res = v.rs ^ v.rt; end
        6'h27: begin e.fn = C_NOR; e.res = ~(v.rs | v.rt); end
        6'h2A: begin e.fn = C_SLT;  e.res = ($signed(v.rs) < $signed(v.rt)) ? 32'd1 : 32'd0; end
        6'h2B: begin e.fn = C_SLTU; e.res = (v.rs < v.rt) ? 32'd1 : 32'd0; end
        6'h00: begin e.fn = C_SLL; e.a = {27'd0, v.sh}; e.res = v.rt << v.sh; end
        6'h02: begin e.fn = C_SRL; e.a = {27'd0, v.sh}; e.res = v.rt >> v.sh; end
        6'h03: begin e.fn = C_SRA; e.a = {27'd0, v.sh}; e.res = $signed(v.rt) >>> v.sh; end
        6'h04: begin e.fn = C_SLL; e.res = v.rt << v.rs[4:0]; end
        6'h06: begin e.fn = C_SRL; e.res = v.rt >> v.rs[4:0]; end
        6'h07: begin e.fn = C_SRA; e.res = $signed(v.rt) >>> v.rs[4:0]; end
        default: e.ill = 1'b1;
      endcase
    end else begin
      case (v.op)
        6'h08, 6'h09, 6'h23, 6'h2B: begin
          e.fn = C_ADD; e.b = se; e.res = v.rs + se; kind = 1; y = se;
        end
        6'h0A: begin e.fn = C_SLT;  e.b = se; e.res = ($signed(v.rs) < $signed(se)) ? 32'd1 : 32'd0; end
        6'h0B: begin e.fn = C_SLTU; e.b = se; e.res = (v.rs < se) ? 32'd1 : 32'd0; end
        6'h0C: begin e.fn = C_AND; e.b = ze; e.res = v.rs & ze; end
        6'h0D: begin e.fn = C_OR;  e.b = ze; e.res = v.rs | ze; end
        6'h0E: begin e.fn = C_XOR; e.b = ze; e.res = v.rs ^ ze; end
        6'h0F: begin e.fn = C_SLL; e.a = 32'd16; e.b = ze; e.res = {v.imm, 16'h0}; end
        6'h04, 6'h05: begin e.fn = C_SUB; e.res = v.rs - v.rt; kind = 2; end
        default: e.ill = 1'b1;
      endcase
    end
    if (e.ill) begin
      e.a = 32'd0; e.b = 32'd0; e.fn = C_ADD; e.res = 32'd0; kind = 0;
    end
    e.flg = flags_of(e.res, kind, v.rs, y);
    return e;
  endfunction

  // Model: up to two instructions in flight, oldest first; head is the
  // response slot when w_occ, the youngest drives the ALU when d_occ.
  exp_t mq[$];
  bit   d_occ = 1'b0;
  bit   w_occ = 1'b0;
  int   acc_cnt = 0;
  int   rsp_cnt = 0;
  int   ill_cnt = 0;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mq.delete();
      d_occ = 1'b0; w_occ = 1'b0;
      acc_cnt = 0; rsp_cnt = 0; ill_cnt = 0;
    end else begin
      bit   fire, move, acc;
      vec_t v;
      fire = w_occ && bus.rsp_ready;
      move = d_occ && (!w_occ || bus.rsp_ready);
      acc  = bus.req_valid && !(d_occ && w_occ && !bus.rsp_ready);
      if (fire) begin
        if (mq[0].ill) ill_cnt++;
        void'(mq.pop_front());
        rsp_cnt++;
        w_occ = 1'b0;
      end
      if (move) begin
        w_occ = 1'b1;
        d_occ = 1'b0;
      end
      if (acc) begin
        v.op = bus.req_op; v.funct = bus.req_funct; v.sh = bus.req_shamt;
        v.imm = bus.req_imm; v.rs = bus.req_rs; v.rt = bus.req_rt;
        mq.push_back(exp_of(v));
        d_occ = 1'b1;
        acc_cnt++;
      end
    end
  end

  always @(negedge clock) begin
    if (reset_n) begin
      exp_t e;
      chk("req_ready", bus.req_ready, !(d_occ && w_occ && !bus.rsp_ready));
      chk("rsp_valid", bus.rsp_valid, w_occ);
      if (w_occ) begin
        chk("rsp_result", bus.rsp_result, mq[0].res);
        chk("rsp_flags", bus.rsp_flags, mq[0].flg);
        chk("rsp_illegal", bus.rsp_illegal, mq[0].ill);
      end
      if (d_occ) begin
        e = mq[w_occ ? 1 : 0];
        chk("alu_A", bus.alu_A, e.a);
        chk("alu_B", bus.alu_B, e.b);
        chk("alu_fn", bus.alu_fn, e.fn);
      end
`ifdef ALU_ISSUE_STATS_EN
      chk("stat_issued", stat_issued, STATS_W'(rsp_cnt));
      chk("stat_illegal", stat_illegal, STATS_W'(ill_cnt));
`endif
    end
  end

  function automatic vec_t mk(input logic [5:0] op, input logic [5:0] funct,
                              input logic [4:0] sh, input logic [15:0] imm,
                              input logic [31:0] rs, input logic [31:0] rt);
    vec_t v;
    v.op = op; v.funct = funct; v.sh = sh; v.imm = imm; v.rs = rs; v.rt = rt;
    return v;
  endfunction

  task automatic sync();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input vec_t v);
    int   guard;
    logic acc;
    guard = 0;
    acc   = 1'b0;
    bus.req_op = v.op; bus.req_funct = v.funct; bus.req_shamt = v.sh;
    bus.req_imm = v.imm; bus.req_rs = v.rs; bus.req_rt = v.rt;
    bus.req_valid = 1'b1;
    while (!acc && guard < 60) begin
      @(negedge clock);
      acc = bus.req_ready;
      @(posedge clock);
      #1;
      guard++;
    end
    bus.req_valid = 1'b0;
    if (!acc) chk("send_accept_timeout", 32'(acc), 32'd1);
  endtask

  vec_t vecs[24];
  logic [39:0] bp_pat = 40'hA5_C3_96_E1_7B;

  initial begin
    int base;
    vecs[0]  = mk(6'h00, 6'h03, 5'd4,  16'h0, 32'h0, 32'h8000_0010);
    vecs[1]  = mk(6'h00, 6'h06, 5'd0,  16'h0, 32'h0000_0024, 32'hF000_0000);
    vecs[2]  = mk(6'h00, 6'h27, 5'd0,  16'h0, 32'h0F0F_0000, 32'h00FF_00FF);
    vecs[3]  = mk(6'h00, 6'h22, 5'd0,  16'h0, 32'h8000_0000, 32'h1);
    vecs[4]  = mk(6'h00, 6'h20, 5'd0,  16'h0, 32'h7FFF_FFFF, 32'h1);
    vecs[5]  = mk(6'h04, 6'h00, 5'd0,  16'h0, 32'd5, 32'd5);
    vecs[6]  = mk(6'h05, 6'h00, 5'd0,  16'h0, 32'd3, 32'd9);
    vecs[7]  = mk(6'h23, 6'h00, 5'd0,  16'hFFFC, 32'h1000, 32'h0);
    vecs[8]  = mk(6'h2B, 6'h00, 5'd0,  16'h0010, 32'h2000, 32'h77);
    vecs[9]  = mk(6'h0E, 6'h00, 5'd0,  16'hFFFF, 32'h1234_5678, 32'h0);
    vecs[10] = mk(6'h0D, 6'h00, 5'd0,  16'h8000, 32'h0, 32'h0);
    vecs[11] = mk(6'h0A, 6'h00, 5'd0,  16'hFFFF, 32'hFFFF_FFFE, 32'h0);
    vecs[12] = mk(6'h0B, 6'h00, 5'd0,  16'hFFFF, 32'd5, 32'h0);
    vecs[13] = mk(6'h00, 6'h00, 5'd31, 16'h0, 32'hFFFF, 32'd3);
    vecs[14] = mk(6'h00, 6'h02, 5'd0,  16'h0, 32'h0, 32'hDEAD_BEEF);
    vecs[15] = mk(6'h00, 6'h01, 5'd0,  16'h0, 32'h11, 32'h22);
    vecs[16] = mk(6'h00, 6'h07, 5'd0,  16'h0, 32'hFFFF_FFFF, 32'h8000_0000);
    vecs[17] = mk(6'h00, 6'h23, 5'd0,  16'h0, 32'd1, 32'd2);
    vecs[18] = mk(6'h00, 6'h21, 5'd0,  16'h0, 32'hFFFF_FFFF, 32'd1);
    vecs[19] = mk(6'h00, 6'h04, 5'd0,  16'h0, 32'h0000_0020, 32'h1234_5678);
    vecs[20] = mk(6'h00, 6'h24, 5'd0,  16'h0, 32'hF0F0_F0F0, 32'hFF00_FF00);
    vecs[21] = mk(6'h00, 6'h25, 5'd0,  16'h0, 32'hF0F0_0000, 32'h0000_0F0F);
    vecs[22] = mk(6'h00, 6'h26, 5'd0,  16'h0, 32'hAAAA_5555, 32'hFFFF_0000);
    vecs[23] = mk(6'h02, 6'h20, 5'd0,  16'h0, 32'd1, 32'd1);

    bus.req_valid = 1'b0; bus.req_op = '0; bus.req_funct = '0; bus.req_shamt = '0;
    bus.req_imm = '0; bus.req_rs = '0; bus.req_rt = '0; bus.rsp_ready = 1'b1;

    #12;
    chk("reset_alu_A", bus.alu_A, 32'd0);
    chk("reset_alu_B", bus.alu_B, 32'd0);
    chk("reset_alu_fn", bus.alu_fn, 32'b00001);
    chk("reset_rsp_valid", bus.rsp_valid, 32'd0);
    chk("reset_rsp_result", bus.rsp_result, 32'd0);
    chk("reset_rsp_flags", bus.rsp_flags, 32'd0);
    chk("reset_rsp_illegal", bus.rsp_illegal, 32'd0);
    sync();
    reset_n = 1'b1;
    @(negedge clock);
    chk("ready_after_reset", bus.req_ready, 32'd1);

    // ADD 7+5: fn in the cycle after accept, response the cycle after that.
    sync();
    send(mk(6'h00, 6'h20, 5'd0, 16'h0, 32'd7, 32'd5));
    @(negedge clock);
    chk("add_fn", bus.alu_fn, 32'b00001);
    @(negedge clock);
    chk("add_rsp_valid", bus.rsp_valid, 32'd1);
    chk("add_result", bus.rsp_result, 32'd12);
    chk("add_flags", bus.rsp_flags, 32'b0000);

    sync();
    send(mk(6'h00, 6'h2A, 5'd0, 16'h0, 32'hFFFF_FFFF, 32'd1));
    @(negedge clock);
    chk("slt_fn", bus.alu_fn, 32'b10011);
    @(negedge clock);
    chk("slt_result", bus.rsp_result, 32'd1);

    sync();
    send(mk(6'h00, 6'h2B, 5'd0, 16'h0, 32'hFFFF_FFFF, 32'd1));
    @(negedge clock);
    chk("sltu_fn", bus.alu_fn, 32'b10111);
    @(negedge clock);
    chk("sltu_result", bus.rsp_result, 32'd0);

    sync();
    send(mk(6'h0F, 6'h00, 5'd0, 16'hABCD, 32'h1234_5678, 32'h0));
    @(negedge clock);
    chk("lui_A", bus.alu_A, 32'd16);
    chk("lui_B", bus.alu_B, 32'h0000_ABCD);
    chk("lui_fn", bus.alu_fn, 32'b00010);
    @(negedge clock);
    chk("lui_result", bus.rsp_result, 32'hABCD_0000);

    sync();
    send(mk(6'h0C, 6'h00, 5'd0, 16'h8001, 32'hFFFF_FFFF, 32'h0));
    @(negedge clock);
    chk("andi_B", bus.alu_B, 32'h0000_8001);
    @(negedge clock);
    chk("andi_result", bus.rsp_result, 32'h0000_8001);

    sync();
    send(mk(6'h08, 6'h00, 5'd0, 16'hFFFF, 32'd1, 32'h0));
    @(negedge clock);
    chk("addi_B", bus.alu_B, 32'hFFFF_FFFF);
    @(negedge clock);
    chk("addi_result", bus.rsp_result, 32'd0);
    chk("addi_Z", bus.rsp_flags[0], 32'd1);

    sync();
    send(mk(6'h3F, 6'h00, 5'd0, 16'h1234, 32'h55, 32'h66));
    @(negedge clock);
    @(negedge clock);
    chk("illegal_flag", bus.rsp_illegal, 32'd1);
    chk("illegal_result", bus.rsp_result, 32'd0);
    chk("illegal_flags", bus.rsp_flags, 32'b0001);

    // Backpressure: two accepts fill D and W, the third waits.
    sync();
    sync();
    base = rsp_cnt;
    bus.rsp_ready = 1'b0;
    send(mk(6'h00, 6'h20, 5'd0, 16'h0, 32'd1, 32'd2));
    send(mk(6'h00, 6'h22, 5'd0, 16'h0, 32'd10, 32'd3));
    bus.req_op = 6'h00; bus.req_funct = 6'h25; bus.req_rs = 32'hF0; bus.req_rt = 32'h0F;
    bus.req_valid = 1'b1;
    @(negedge clock);
    chk("bp_ready_drop", bus.req_ready, 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      chk("bp_held_result", bus.rsp_result, 32'd3);
      chk("bp_held_valid", bus.rsp_valid, 32'd1);
    end
    sync();
    bus.rsp_ready = 1'b1;
    send(mk(6'h00, 6'h25, 5'd0, 16'h0, 32'hF0, 32'h0F));
    repeat (4) sync();
    chk("bp_drained_count", 32'(rsp_cnt - base), 32'd3);

    // Reset with both stages full drops everything.
    bus.rsp_ready = 1'b0;
    send(mk(6'h00, 6'h20, 5'd0, 16'h0, 32'd4, 32'd4));
    send(mk(6'h00, 6'h20, 5'd0, 16'h0, 32'd8, 32'd8));
    @(negedge clock);
    chk("prereset_rsp_valid", bus.rsp_valid, 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("reset_drop_valid", bus.rsp_valid, 32'd0);
    sync();
    reset_n = 1'b1;
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      chk("no_rsp_after_reset", bus.rsp_valid, 32'd0);
    end

    // Full table at full rate, then again under a fixed stall pattern.
    sync();
    foreach (vecs[i]) send(vecs[i]);
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          bus.rsp_ready = bp_pat[i];
          sync();
        end
        bus.rsp_ready = 1'b1;
      end
      begin
        foreach (vecs[i]) send(vecs[i]);
      end
    join
    repeat (6) sync();
    chk("final_queue_empty", 32'(mq.size()), 32'd0);
    chk("final_all_answered", 32'(rsp_cnt), 32'(acc_cnt));
    chk("final_answer_count", 32'(rsp_cnt), 32'd48);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/alu_issue_unit.md
Name: alu_issue_unit

Overview:
Front end that drives the 32-bit MIPS ALU from decoded instruction fields. Accepts one instruction per cycle over a valid/ready handshake and encodes opcode/funct into the 5-bit ALUfn {subtract, bool1, bool0, shft, math}. Forms the A/B operands (immediate extension, shamt, LUI), drives the ALU combinationally from a registered stage, and captures R plus flags into a response stage with backpressure. Two-stage pipeline between the register-read stage and writeback.

Parameters:
N, 32, datapath width; must be 32 for the MIPS encodings.
STATS_W, 16, width of the optional statistics counters.

Ports:
clock  in  1  system clock, rising edge
reset_n  in  1  asynchronous, active-low reset
req_valid  in  1  request present
req_ready  out  1  unit can accept a request this cycle
req_op  in  6  instruction opcode [31:26]
req_funct  in  6  funct [5:0]
req_shamt  in  5  shamt [10:6]
req_imm  in  16  immediate [15:0]
req_rs  in  N  rs register value
req_rt  in  N  rt register value
alu_A  out  N  ALU operand A
alu_B  out  N  ALU operand B
alu_fn  out  5  ALUfn
alu_R  in  N  ALU result
alu_flags  in  4  {N,V,C,Z} from ALU
rsp_valid  out  1  response present
rsp_ready  in  1  downstream accepts the response
rsp_result  out  N  captured R
rsp_flags  out  4  captured {N,V,C,Z}
rsp_illegal  out  1  unsupported op/funct

Behaviour:
- Reset (async, reset_n=0): d_valid=0, w_valid=0, and all D and W registers cleared, so alu_A=0, alu_B=0, alu_fn=5'b00001, rsp_valid=0, rsp_result=0, rsp_flags=0, rsp_illegal=0. req_ready=1 from the first clock edge after release. Reset mid-operation drops all in-flight work. No partial responses.
- Stages: D (decoded A, B, fn, illegal, d_valid), then W (R, flags, illegal, w_valid). alu_A/alu_B/alu_fn come straight from the D registers, with no combinational path from req_*.
- Advance rules: w_adv = d_valid & (~w_valid | rsp_ready). req_ready = ~d_valid | w_adv. A request is accepted on req_valid & req_ready. W loads on w_adv. W clears to invalid on rsp_ready & ~w_adv. D clears when w_adv fires without a new accept.
- Latency: a request accepted at edge t drives the ALU in cycle t+1. rsp_valid rises after edge t+2. Throughput is 1/cycle while rsp_ready=1.
- Backpressure: while rsp_valid & ~rsp_ready, the W outputs are held stable. D holds, and req_ready drops once D is full.
- ALUfn encodings: ADD 00001, SUB 10001, SLL 00010, SRL 01010, SRA 01110, AND 00000, OR 00100, XOR 01000, NOR 01100, SLT 10011, SLTU 10111.
- R-type (op=0), each listed as funct → fn:
  - 0x20/0x21 → ADD; 0x22/0x23 → SUB; 0x24 → AND; 0x25 → OR; 0x26 → XOR; 0x27 → NOR; 0x2A → SLT; 0x2B → SLTU. For all of these, A=rs and B=rt.
  - 0x00/0x02/0x03 → SLL/SRL/SRA with A=zext(shamt), B=rt.
  - 0x04/0x06/0x07 → SLLV/SRLV/SRAV with A=rs, B=rt.
- I-type, each listed as opcode → fn:
  - 0x08/0x09 → ADD, B=sext(imm).
  - 0x0A → SLT, B=sext(imm); 0x0B → SLTU, B=sext(imm).
  - 0x0C/0x0D/0x0E → AND/OR/XOR, B=zext(imm).
  - 0x0F LUI → SLL with A=16, B=zext(imm).
  - 0x23/0x2B LW/SW → ADD, B=sext(imm).
  - 0x04/0x05 BEQ/BNE → SUB, B=rt.
  - A=rs unless stated otherwise.
- Illegal (any other op, or an unlisted funct under op=0): fn=ADD, A=B=0, illegal=1. The request is still accepted and answered, so rsp_result=0 and rsp_flags=0001.
- The ALU uses only A[4:0] as the shift amount. The upper bits of A are passed unchanged.

Optional Feature:
ALU_ISSUE_STATS_EN: when defined, adds outputs stat_issued[STATS_W-1:0] and stat_illegal[STATS_W-1:0].
- stat_issued increments on each response handshake (rsp_valid & rsp_ready).
- stat_illegal increments on each such handshake that has rsp_illegal=1.
- Both counters wrap at 2^STATS_W, and both are cleared by reset_n.
When undefined, these ports and counters do not exist and the rest of the behaviour is identical.

Decomposition:
Package alu_issue_pkg holds:
- the ALUfn localparams (FN_ADD, FN_SUB, FN_SLL, FN_SRL, FN_SRA, FN_AND, FN_OR, FN_XOR, FN_NOR, FN_SLT, FN_SLTU);
- the opcode/funct constants;
- the struct typedef issue_t {A, B, fn, illegal}.

One combinational sub-module, alu_issue_decode, maps (op, funct, shamt, imm, rs, rt) to issue_t. The top level holds only the pipeline registers and the handshake.

Test Plan:
- ADD: accept op=0 funct=0x20 with rs=7, rt=5 and rsp_ready=1 → alu_fn=00001 in cycle t+1; rsp_result=12 and flags=0000 at t+2.
- SLT signed: rs=0xFFFFFFFF, rt=1 → fn=10011, result=1. Repeat with SLTU → fn=10111, result=0.
- LUI: op=0x0F, imm=0xABCD → alu_A=16, alu_B=0x0000ABCD, fn=00010, result=0xABCD0000.
- Immediate extension: ANDI imm=0x8001, rs=0xFFFFFFFF → B=0x00008001, result=0x00008001. ADDI imm=0xFFFF, rs=1 → B=0xFFFFFFFF, result=0, Z=1.
- Backpressure: issue 3 back-to-back ops with rsp_ready=0 → req_ready drops after 2 accepts. The first response stays held and stable. Releasing rsp_ready drains all 3 in order with no loss or duplication.
- Illegal and reset: op=0x3F → rsp_illegal=1, result=0, flags=0001. Asserting reset_n=0 with both stages full → rsp_valid=0 immediately, with no response after release.
